// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable controller: FSM state codes
// and the default divider width.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_STEP = 2'b01,
        S_RUN  = 2'b10,
        S_STOP = 2'b11
    } state_t;

    localparam int DIV_W_DEF  = 32;
    localparam int CE_COUNT_W = 32;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a stability
// counter; emits the debounced level and a one-cycle pulse on its rising edge.
module btn_debounce #(
    parameter int DEB_CYC = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int SYNC_STAGES = 2;
    localparam int CW          = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg, cnt_next;
    logic                   level_reg, level_next;
    logic                   rise_reg, rise_next;
    logic                   sync_bit;

    assign sync_bit = sync_reg[SYNC_STAGES-1];

    // The level only moves after DEB_CYC consecutive samples disagree with it.
    always_comb begin
        cnt_next   = '0;
        level_next = level_reg;
        rise_next  = 1'b0;
        if (sync_bit != level_reg) begin
            if (cnt_reg == CNT_LAST) begin
                level_next = sync_bit;
                rise_next  = sync_bit;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg  <= '0;
            cnt_reg   <= '0;
            level_reg <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[SYNC_STAGES-2:0], raw};
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable generator: free-run at a programmable divide ratio,
// single-step from a debounced button, or stop on a CPU halt request.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 100000,
    parameter int DEB_CYC     = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_run,
    input  logic                  step_btn,
    input  logic                  halt_req,
    input  logic                  div_load,
    input  logic [DIV_W-1:0]      div_value,
    output logic                  cpu_ce,
    output logic [1:0]            state,
    output logic [CE_COUNT_W-1:0] ce_count
);

    state_t                 state_reg, state_next;
    logic [DIV_W-1:0]       cnt_reg, cnt_next;
    logic [DIV_W-1:0]       div_reg, div_next;
    logic [DIV_W-1:0]       div_cur, div_last;
    logic                   ce_reg, ce_next;
    logic [CE_COUNT_W-1:0]  ce_count_reg, ce_count_next;
    logic                   step_level, step_rise, step_go;
    logic                   period_done;

    btn_debounce #(
        .DEB_CYC(DEB_CYC)
    ) u_step_deb (
        .clk   (clk),
        .rst   (rst),
        .raw   (step_btn),
        .level (step_level),
        .rise  (step_rise)
    );

    assign step_go = step_rise & step_level;

    // A ratio loaded this cycle already governs this cycle's compare, so a
    // shrinking ratio ends the period immediately instead of overrunning.
    assign div_cur     = div_load ? div_value : div_reg;
    assign div_last    = (div_cur == '0) ? '0 : div_cur - DIV_W'(1);
    assign period_done = (cnt_reg >= div_last);
    assign div_next    = div_cur;

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        ce_next    = 1'b0;
        case (state_reg)
            S_HALT: begin
                if (mode_run && !halt_req) begin
                    state_next = S_RUN;
                end else if (step_go) begin
                    state_next = S_STEP;
                    ce_next    = 1'b1;
                end
            end
            S_STEP: begin
                state_next = S_HALT;
            end
            S_RUN: begin
                if (period_done) begin
                    ce_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
                // A pulse already due is still issued when leaving RUN.
                if (halt_req) begin
                    state_next = S_STOP;
                end else if (!mode_run) begin
                    state_next = S_HALT;
                end
            end
            S_STOP: begin
                if (!mode_run) begin
                    state_next = S_HALT;
                end
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    assign ce_count_next = ce_count_reg + {{(CE_COUNT_W-1){1'b0}}, ce_next};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_HALT;
            cnt_reg      <= '0;
            div_reg      <= DIV_W'(DEFAULT_DIV);
            ce_reg       <= 1'b0;
            ce_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            ce_reg       <= ce_next;
            ce_count_reg <= ce_count_next;
        end
    end

    assign cpu_ce   = ce_reg;
    assign state    = state_reg;
    assign ce_count = ce_count_reg;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl with DEFAULT_DIV=4 and DEB_CYC=3:
// a directed vector table, corner-case sequences, then random stimulus vs a model.
module tb_cpu_clk_ctrl;

    localparam int DIV_W = 32;
    localparam int DEB   = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             mode_run = 1'b0;
    logic             step_btn = 1'b0;
    logic             halt_req = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_value = '0;
    logic             cpu_ce;
    logic [1:0]       state;
    logic [31:0]      ce_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (4),
        .DEB_CYC     (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode_run  (mode_run),
        .step_btn  (step_btn),
        .halt_req  (halt_req),
        .div_load  (div_load),
        .div_value (div_value),
        .cpu_ce    (cpu_ce),
        .state     (state),
        .ce_count  (ce_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        mode;
        logic        halt;
        logic        load;
        logic [31:0] val;
        logic        step;
        logic [1:0]  st;
        logic        ce;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int n, input logic mode, input logic halt, input logic load,
                       input logic [31:0] val, input logic step,
                       input logic [1:0] st, input logic ce, input logic [31:0] cnt);
        vec_t v;
        v.mode = mode; v.halt = halt; v.load = load; v.val = val; v.step = step;
        v.st = st; v.ce = ce; v.cnt = cnt;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    // ---------------- behavioural reference model ----------------
    int          m_state;
    bit          m_ce;
    int unsigned m_count;
    int unsigned m_div;
    int unsigned m_elapsed;
    bit          m_rawq[$];
    bit          m_win[$];
    bit          m_lvl;
    bit          m_rise;

    task automatic model_reset();
        m_state = 0; m_ce = 0; m_count = 0; m_div = 4; m_elapsed = 0;
        m_rawq = '{0, 0};
        m_win = {};
        for (int i = 0; i < DEB; i++) m_win.push_back(1'b0);
        m_lvl = 0; m_rise = 0;
    endtask

    // Advances the model by one clock edge given the inputs held before it.
    task automatic model_edge(input bit mode, input bit halt, input bit load,
                              input int unsigned val, input bit raw);
        int unsigned d;
        int          nxt;
        bit          ce;
        bit          smp;
        bit          flip;
        d = load ? val : m_div;
        if (d == 0) d = 1;
        ce = 0;
        nxt = m_state;
        case (m_state)
            0: begin
                if (mode && !halt) begin
                    nxt = 2; m_elapsed = 0;
                end else if (m_rise) begin
                    nxt = 1; ce = 1;
                end
            end
            1: nxt = 0;
            2: begin
                m_elapsed++;
                if (m_elapsed >= d) begin
                    ce = 1; m_elapsed = 0;
                end
                if (halt) nxt = 3;
                else if (!mode) nxt = 0;
            end
            default: if (!mode) nxt = 0;
        endcase
        // Button: seen two edges late, level flips when DEB samples all disagree.
        smp = m_rawq.pop_front();
        m_rawq.push_back(raw);
        void'(m_win.pop_front());
        m_win.push_back(smp);
        flip = 1;
        foreach (m_win[i]) if (m_win[i] == m_lvl) flip = 0;
        m_rise = flip && !m_lvl;
        if (flip) m_lvl = !m_lvl;
        m_state = nxt;
        m_ce = ce;
        m_count = m_count + ce;
        if (load) m_div = val;
    endtask

    initial begin
        // ---- reset state ----
        tick();
        tick();
        check("reset.state", state, 0);
        check("reset.ce", cpu_ce, 0);
        check("reset.count", ce_count, 0);
        rst = 1'b0;

        // ---- table: run pulses, halt on a due pulse, stop ignores steps ----
        add(1,  1, 0, 0, 0, 0, 2'd2, 0, 0);
        add(3,  1, 0, 0, 0, 0, 2'd2, 0, 0);
        add(1,  1, 0, 0, 0, 0, 2'd2, 1, 1);
        add(3,  1, 0, 0, 0, 0, 2'd2, 0, 1);
        add(1,  1, 0, 0, 0, 0, 2'd2, 1, 2);
        add(3,  1, 0, 0, 0, 0, 2'd2, 0, 2);
        add(1,  1, 0, 0, 0, 0, 2'd2, 1, 3);
        add(3,  1, 0, 0, 0, 0, 2'd2, 0, 3);
        add(1,  1, 1, 0, 0, 0, 2'd3, 1, 4);
        add(1,  1, 1, 0, 0, 0, 2'd3, 0, 4);
        add(10, 1, 0, 0, 0, 1, 2'd3, 0, 4);
        add(8,  0, 0, 0, 0, 0, 2'd0, 0, 4);
        for (int i = 0; i < tbl.size(); i++) begin
            mode_run = tbl[i].mode; halt_req = tbl[i].halt; div_load = tbl[i].load;
            div_value = tbl[i].val; step_btn = tbl[i].step;
            tick();
            check($sformatf("tbl%0d.state", i), state, tbl[i].st);
            check($sformatf("tbl%0d.ce", i), cpu_ce, tbl[i].ce);
            check($sformatf("tbl%0d.count", i), ce_count, tbl[i].cnt);
        end

        // ---- step press in HALT: one pulse, 6th edge after press ----
        step_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check($sformatf("step%0d.ce", i), cpu_ce, (i == 6) ? 1 : 0);
            check($sformatf("step%0d.state", i), state, (i == 6) ? 1 : 0);
        end
        check("step.count", ce_count, 5);
        step_btn = 1'b0;
        repeat (10) tick();
        check("release.count", ce_count, 5);
        step_btn = 1'b1;
        tick();
        tick();
        step_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("glitch%0d.ce", i), cpu_ce, 0);
        end
        check("glitch.count", ce_count, 5);

        // ---- divide ratio 0, then shrink mid-period ----
        mode_run = 1'b1; div_load = 1'b1; div_value = 0;
        tick();
        check("div0.state", state, 2);
        check("div0.entry_ce", cpu_ce, 0);
        div_load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("div0.ce%0d", k), cpu_ce, 1);
        end
        check("div0.count", ce_count, 11);
        div_load = 1'b1; div_value = 4;
        tick();
        check("div4.ce", cpu_ce, 0);
        div_value = 2;
        tick();
        check("div2.early_ce", cpu_ce, 1);
        div_load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("div2.ce%0d", k), cpu_ce, k % 2);
        end
        check("div2.count", ce_count, 14);

        // ---- halt_req and mode_run=0 together: halt wins ----
        halt_req = 1'b1; mode_run = 1'b0;
        tick();
        check("both.state", state, 3);
        halt_req = 1'b0;
        tick();
        check("stop_exit.state", state, 0);

        // ---- halt_req held in HALT blocks RUN ----
        mode_run = 1'b1; halt_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("blocked%0d.state", k), state, 0);
        end
        halt_req = 1'b0;
        tick();
        check("unblocked.state", state, 2);

        // ---- asynchronous reset mid-run ----
        repeat (3) tick();
        #3 rst = 1'b1;
        #1;
        check("async_rst.ce", cpu_ce, 0);
        check("async_rst.count", ce_count, 0);
        check("async_rst.state", state, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rerun.state", state, 2);
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("rerun.ce%0d", k), cpu_ce, (k == 4) ? 1 : 0);
        end

        // ---- randomized stimulus against the model ----
        mode_run = 0; halt_req = 0; div_load = 0; div_value = 0; step_btn = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) mode_run = ~mode_run;
            if ($urandom_range(24) == 0) halt_req = ~halt_req;
            div_load  = ($urandom_range(29) == 0);
            div_value = $urandom_range(6);
            if ($urandom_range(5) == 0) step_btn = ~step_btn;
            model_edge(mode_run, halt_req, div_load, div_value, step_btn);
            tick();
            check($sformatf("rnd%0d.state", c), state, m_state);
            check($sformatf("rnd%0d.ce", c), cpu_ce, m_ce);
            check($sformatf("rnd%0d.count", c), ce_count, m_count);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
